// File: rtl/shiftreg_rx_fifo.sv
// ---------------------------------------------------------------------------
// shiftreg_rx_fifo
//
// Receive-side buffer for the gated shift register. The upstream stream is
// valid-only, so each beat is either stored this cycle or lost. Stored beats
// are offered to the consumer through a valid/ready handshake. Beats that
// arrive while the FIFO is full are counted and flagged.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   valid_i     incoming beat valid (no backpressure)
//   data_i      incoming beat payload
//   valid_o     head entry available
//   ready_i     consumer accepts head entry
//   data_o      head entry payload (zero while valid_o is low)
//   usage_o     number of stored entries, 0..FifoDepth
//   full_o      usage_o == FifoDepth
//   empty_o     usage_o == 0
//   overflow_o  sticky flag, set once a beat has been dropped
//   drop_cnt_o  saturating count of dropped beats
//   clr_i       synchronous clear of overflow_o and drop_cnt_o
// ---------------------------------------------------------------------------
module shiftreg_rx_fifo #(
  parameter int FifoDepth = 8,
  parameter int DataWidth = 32,
  localparam type dtype = logic [DataWidth-1:0],
  localparam int UsageWidth = $clog2(FifoDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  dtype                  data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output dtype                  data_o,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic [15:0]           drop_cnt_o,
  input  logic                  clr_i
);

  localparam int PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam logic [PtrWidth-1:0]   LastIdx  = PtrWidth'(FifoDepth - 1);
  localparam logic [UsageWidth-1:0] DepthVal = UsageWidth'(FifoDepth);

  if (FifoDepth < 2) begin : gDepthCheck
    $error("shiftreg_rx_fifo: FifoDepth must be at least 2");
  end

  dtype                  mem_q [FifoDepth];
  logic [PtrWidth-1:0]   wrPtr_q, wrPtr_d;
  logic [PtrWidth-1:0]   rdPtr_q, rdPtr_d;
  logic [UsageWidth-1:0] usage_q, usage_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           dropCnt_q, dropCnt_d;

  logic full, empty, push, pop, drop;

  // Status comes only from the usage register, so full/empty carry no
  // combinational path from the inputs. A pop frees a slot in the same
  // cycle, which lets a full FIFO keep accepting while it is drained.
  assign full  = (usage_q == DepthVal);
  assign empty = (usage_q == '0);
  assign pop   = ~empty & ready_i;
  assign push  = valid_i & (~full | pop);
  assign drop  = valid_i & full & ~pop;

  // Pointer and occupancy next-state. Depth need not be a power of two,
  // so each pointer wraps on an explicit compare with the last index.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    usage_d = usage_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == LastIdx) ? '0 : wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == LastIdx) ? '0 : rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
  end

  // Overflow bookkeeping. A drop in the same cycle as a clear takes
  // priority: the clear applies first and the drop then counts as one.
  always_comb begin
    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_i) begin
        dropCnt_d = 16'd1;
      end else if (dropCnt_q != 16'hFFFF) begin
        dropCnt_d = dropCnt_q + 16'd1;
      end
    end else if (clr_i) begin
      overflow_d = 1'b0;
      dropCnt_d  = 16'd0;
    end
  end

  // Control state; reset discards all stored entries immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      usage_q    <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= 16'd0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      usage_q    <= usage_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
    end
  end

  // Payload storage needs no reset: an entry is only visible once usage
  // counts it, and the output mux below hides stale contents.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Registered read (no fall-through); the head only changes on a pop,
  // so data_o holds steady while the consumer stalls.
  assign valid_o    = ~empty;
  assign data_o     = empty ? '0 : mem_q[rdPtr_q];
  assign usage_o    = usage_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = dropCnt_q;

  assert property (@(posedge clk_i) disable iff (!rst_ni) usage_q <= DepthVal)
    else $error("shiftreg_rx_fifo: usage exceeds depth");
  assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> !empty)
    else $error("shiftreg_rx_fifo: pop while empty");

endmodule

// File: tb/tb_shiftreg_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_shiftreg_rx_fifo
//
// Drives one shared input stream into two FIFOs (depth 8 and depth 5).
// Stimulus pushes every beat it expects to be accepted into a per-FIFO
// reference queue; a negedge monitor per FIFO pops and compares on every
// handshake. Status outputs are compared with hand-computed constants.
// ---------------------------------------------------------------------------
module tb_shiftreg_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        validIn;
  logic [31:0] dataIn;
  logic        readyIn;
  logic        clrIn;

  logic        valid8, full8, empty8, ovf8;
  logic [31:0] data8;
  logic [3:0]  usage8;
  logic [15:0] drop8;

  logic        valid5, full5, empty5, ovf5;
  logic [31:0] data5;
  logic [2:0]  usage5;
  logic [15:0] drop5;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expQ8[$];
  logic [31:0] expQ5[$];
  int cnt8 = 0, cnt5 = 0;
  int popCount8 = 0, popCount5 = 0;
  int modelDrops8 = 0, modelDrops5 = 0;

  shiftreg_rx_fifo #(.FifoDepth(8), .DataWidth(32)) dut8 (
    .clk_i(clk), .rst_ni(rstN), .valid_i(validIn), .data_i(dataIn),
    .valid_o(valid8), .ready_i(readyIn), .data_o(data8), .usage_o(usage8),
    .full_o(full8), .empty_o(empty8), .overflow_o(ovf8), .drop_cnt_o(drop8),
    .clr_i(clrIn)
  );

  shiftreg_rx_fifo #(.FifoDepth(5), .DataWidth(32)) dut5 (
    .clk_i(clk), .rst_ni(rstN), .valid_i(validIn), .data_i(dataIn),
    .valid_o(valid5), .ready_i(readyIn), .data_o(data5), .usage_o(usage5),
    .full_o(full5), .empty_o(empty5), .overflow_o(ovf5), .drop_cnt_o(drop5),
    .clr_i(clrIn)
  );

  // One comparison: counts it, and reports actual vs required on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model of one FIFO for a single cycle of stimulus.
  task automatic modelCycle(input int depth, inout int cnt, inout int drops,
                            input logic v, input logic r, input logic c,
                            output logic accept);
    logic popM, dropM;
    popM   = r && (cnt > 0);
    accept = v && ((cnt < depth) || popM);
    dropM  = v && !accept;
    if (accept) cnt++;
    if (popM) cnt--;
    if (dropM) drops = c ? 1 : ((drops < 65535) ? drops + 1 : 65535);
    else if (c) drops = 0;
  endtask

  // Drive one cycle of inputs, record expectations, step past the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic r, input logic c);
    logic acc8, acc5;
    validIn = v;
    dataIn  = d;
    readyIn = r;
    clrIn   = c;
    modelCycle(8, cnt8, modelDrops8, v, r, c, acc8);
    modelCycle(5, cnt5, modelDrops5, v, r, c, acc5);
    if (acc8) expQ8.push_back(d);
    if (acc5) expQ5.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every handshake must deliver the oldest expected beat.
  always @(negedge clk) begin
    if (rstN && valid8 && readyIn) begin
      popCount8++;
      if (expQ8.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL order8: got %0h, expected no output", data8);
      end else begin
        checkOutput("order8", data8, expQ8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rstN && valid5 && readyIn) begin
      popCount5++;
      if (expQ5.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL order5: got %0h, expected no output", data5);
      end else begin
        checkOutput("order5", data5, expQ5.pop_front());
      end
    end
  end

  initial begin
    int pc;
    rstN = 1'b0; validIn = 1'b0; dataIn = '0; readyIn = 1'b0; clrIn = 1'b0;
    #12;
    checkOutput("rst valid",    32'(valid8), 0);
    checkOutput("rst data",     data8, 0);
    checkOutput("rst usage",    32'(usage8), 0);
    checkOutput("rst full",     32'(full8), 0);
    checkOutput("rst empty",    32'(empty8), 1);
    checkOutput("rst overflow", 32'(ovf8), 0);
    checkOutput("rst dropcnt",  32'(drop8), 0);
    checkOutput("rst empty5",   32'(empty5), 1);
    rstN = 1'b1;
    @(posedge clk); #1;

    // Single beat latency.
    applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0);
    checkOutput("lat valid", 32'(valid8), 1);
    checkOutput("lat data",  data8, 32'hA5);
    checkOutput("lat usage", 32'(usage8), 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("lat drained",  32'(usage8), 0);
    checkOutput("lat valid off", 32'(valid8), 0);
    checkOutput("lat overflow", 32'(ovf8), 0);

    // Fill past full with ready low.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 6) checkOutput("fill notfull", 32'(full8), 0);
      if (i == 7) checkOutput("fill full",    32'(full8), 1);
    end
    checkOutput("fill usage",    32'(usage8), 8);
    checkOutput("fill overflow", 32'(ovf8), 1);
    checkOutput("fill drops",    32'(drop8), 2);
    checkOutput("fill drops5",   32'(drop5), 5);
    checkOutput("fill ovf5",     32'(ovf5), 1);

    // Full with push and pop each cycle: no drops, no gaps.
    pc = popCount8;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'(100 + k), 1'b1, 1'b0);
      checkOutput("thru usage", 32'(usage8), 8);
    end
    checkOutput("thru pops",   32'(popCount8 - pc), 5);
    checkOutput("thru drops",  32'(drop8), 2);
    checkOutput("thru drops5", 32'(drop5), 5);

    // Drain.
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain empty",  32'(empty8), 1);
    checkOutput("drain empty5", 32'(empty5), 1);
    checkOutput("drain queue",  32'(expQ8.size()), 0);

    // Random traffic: wrap on both depths.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 32'h1000 + 32'(i),
                    $urandom_range(0, 1) != 0, 1'b0);
    end
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("rand empty8", 32'(empty8), 1);
    checkOutput("rand empty5", 32'(empty5), 1);
    checkOutput("rand queue8", 32'(expQ8.size()), 0);
    checkOutput("rand queue5", 32'(expQ5.size()), 0);
    checkOutput("rand drops8", 32'(drop8), 32'(modelDrops8));
    checkOutput("rand drops5", 32'(drop5), 32'(modelDrops5));

    // Clear, then saturate the drop counter.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("clr drops", 32'(drop8), 0);
    checkOutput("clr ovf",   32'(ovf8), 0);
    for (int i = 0; i < 65548; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    checkOutput("sat drops8", 32'(drop8), 32'hFFFF);
    checkOutput("sat drops5", 32'(drop5), 32'hFFFF);
    checkOutput("sat usage",  32'(usage8), 8);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("clr2 drops", 32'(drop8), 0);
    checkOutput("clr2 ovf",   32'(ovf8), 0);
    checkOutput("clr2 usage", 32'(usage8), 8);
    applyStimulus(1'b1, 32'hDD, 1'b0, 1'b1);
    checkOutput("clrdrop drops",  32'(drop8), 1);
    checkOutput("clrdrop ovf",    32'(ovf8), 1);
    checkOutput("clrdrop drops5", 32'(drop5), 1);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain2 empty", 32'(empty8), 1);

    // Asynchronous reset mid-cycle with 3 entries stored.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
    checkOutput("pre-rst usage", 32'(usage8), 3);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("arst valid",  32'(valid8), 0);
    checkOutput("arst usage",  32'(usage8), 0);
    checkOutput("arst empty",  32'(empty8), 1);
    checkOutput("arst valid5", 32'(valid5), 0);
    expQ8.delete(); expQ5.delete();
    cnt8 = 0; cnt5 = 0; modelDrops8 = 0; modelDrops5 = 0;
    validIn = 1'b1; dataIn = 32'h777;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("inrst usage", 32'(usage8), 0);
    validIn = 1'b0;
    #2;
    rstN = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'hBEEF, 1'b1, 1'b0);
    checkOutput("post data",  data8, 32'hBEEF);
    checkOutput("post valid", 32'(valid8), 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("post empty", 32'(empty8), 1);
    checkOutput("post queue", 32'(expQ8.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
